eb_pack: RTL

Width-up packer feeding the elastic-buffer FIFO. It gathers `RATIO` narrow beats from a req/ack source into one wide word and presents that word on a registered req/ack initiator port, which the FIFO write side consumes directly. A `last` marker closes a partial word early. The block sustains one narrow beat per clock when the wide side does not stall.

---
 rtl/eb_pack_pkg.sv | 18 +
 rtl/eb_pack_if.sv | 32 +++
 rtl/eb_hold_reg.sv | 31 +++
 rtl/eb_pack.sv | 90 +++++++++
 4 files changed

// File: rtl/eb_pack_pkg.sv
// Shared constants and helpers for the eb_pack width-up packer.
// Default geometry, lane-count type and lane addressing used by the RTL and the bench.
package eb_pack_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int RATIO_DEF     = 4;
  localparam int RATIOLOG2_DEF = 2;

  // t_0_ack is high out of reset: nothing is parked yet.
  localparam logic T_ACK_RESET = 1'b1;

  typedef logic [RATIOLOG2_DEF-1:0] lane_cnt_t;

  function automatic int lane_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/eb_pack_if.sv
// Narrow req/ack target side and wide req/ack initiator side of the packer.
// The slave modport is the packer; the master modport is its environment.
interface eb_pack_if
  import eb_pack_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RATIO     = RATIO_DEF,
  parameter int RATIOLOG2 = RATIOLOG2_DEF
);

  logic                   t_0_req;
  logic                   t_0_ack;
  logic [WIDTH-1:0]       t_0_data;
  logic                   t_0_last;

  logic                   i_0_req;
  logic                   i_0_ack;
  logic [WIDTH*RATIO-1:0] i_0_data;
  logic [RATIOLOG2-1:0]   i_0_cnt;
  logic                   i_0_last;

  modport slave (
    input  t_0_req, t_0_data, t_0_last, i_0_ack,
    output t_0_ack, i_0_req, i_0_data, i_0_cnt, i_0_last
  );

  modport master (
    output t_0_req, t_0_data, t_0_last, i_0_ack,
    input  t_0_ack, i_0_req, i_0_data, i_0_cnt, i_0_last
  );

endinterface

// File: rtl/eb_hold_reg.sv
// One-entry req/ack holding register with a generic payload.
// empty_or_draining tells the producer a load this edge will not overwrite a live word.
module eb_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_req,
  input  logic         out_ack,
  output logic [W-1:0] out_data,
  output logic         empty_or_draining
);

  assign empty_or_draining = !out_req || out_ack;

  // A load wins over a drain so a back-to-back word leaves no bubble on out_req.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_req  <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      out_req  <= 1'b1;
      out_data <= load_data;
    end else if (out_ack) begin
      out_req  <= 1'b0;
    end
  end

endmodule

// File: rtl/eb_pack.sv
// Width-up packer: gathers RATIO narrow beats (or fewer, closed by t_0_last) into one
// wide word, parking at most one completed word while the output register is busy.
module eb_pack
  import eb_pack_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RATIO     = RATIO_DEF,
  parameter int RATIOLOG2 = RATIOLOG2_DEF
) (
  input  logic       clk,
  input  logic       reset,
  eb_pack_if.slave   bus
);

  localparam int WORD_W = WIDTH * RATIO;
  localparam int HOLD_W = WORD_W + RATIOLOG2 + 1;

  logic [RATIOLOG2-1:0] lane;
  logic [RATIOLOG2-1:0] acc_cnt;
  logic [WORD_W-1:0]    acc;
  logic [WORD_W-1:0]    new_word;
  logic                 acc_last;
  logic                 pend;
  logic                 beat;
  logic                 completing;
  logic                 empty_or_draining;
  logic                 load;
  logic                 hold_req;
  logic [HOLD_W-1:0]    load_payload;
  logic [HOLD_W-1:0]    hold_payload;

  assign beat         = bus.t_0_req && !pend;
  assign completing   = beat && ((lane == RATIOLOG2'(RATIO - 1)) || bus.t_0_last);
  assign load         = empty_or_draining && (pend || completing);
  assign load_payload = pend ? {acc_last, acc_cnt, acc}
                             : {bus.t_0_last, lane, new_word};
  assign bus.t_0_ack  = !pend;

  // Lanes below the current one come from the accumulator; lanes above it read as
  // zero, so a short word never exposes bytes left over from an earlier word.
  always_comb begin
    new_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(lane)) begin
        new_word[lane_lsb(k, WIDTH) +: WIDTH] = acc[lane_lsb(k, WIDTH) +: WIDTH];
      end else if (k == int'(lane)) begin
        new_word[lane_lsb(k, WIDTH) +: WIDTH] = bus.t_0_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane     <= '0;
      acc      <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      pend     <= !T_ACK_RESET;
    end else if (beat) begin
      acc  <= new_word;
      lane <= completing ? '0 : lane + 1'b1;
      if (completing) begin
        acc_cnt  <= lane;
        acc_last <= bus.t_0_last;
        pend     <= !empty_or_draining;
      end
    end else if (pend && empty_or_draining) begin
      pend <= 1'b0;
    end
  end

  eb_hold_reg #(
    .W (HOLD_W)
  ) u_hold (
    .clk               (clk),
    .reset             (reset),
    .load              (load),
    .load_data         (load_payload),
    .out_req           (hold_req),
    .out_ack           (bus.i_0_ack),
    .out_data          (hold_payload),
    .empty_or_draining (empty_or_draining)
  );

  assign bus.i_0_req  = hold_req;
  assign bus.i_0_data = hold_payload[WORD_W-1:0];
  assign bus.i_0_cnt  = hold_payload[WORD_W +: RATIOLOG2];
  assign bus.i_0_last = hold_payload[HOLD_W-1];

endmodule
